nokia5110_spi_tx: RTL and testbench
===================================

Name: nokia5110_spi_tx

Overview:
- Serial transmitter that drives the Nokia 5110 (PCD8544) display interface.
- Accepts one byte at a time, together with a data/command flag, through a valid/ready handshake.
- Shifts each byte out MSB-first on a generated serial clock, framed by chip-enable.
- Sits between the display-content/command sequencer and the LCD pins. It generates its own serial clock from the system clock at the same 1.5625 MHz rate (50 MHz / 32) that the display path already uses, and sequences the LCD hardware-reset pulse at power-up.

Parameters:
- HALF, 16, system-clock cycles per serial-clock half period (16 gives 50 MHz/32 = 1.5625 MHz); legal range is HALF ≥ 1.
- RST_CYCLES, 1024, system-clock cycles that lcd_rst is held low after reset release; legal range is RST_CYCLES ≥ 1.

Ports:
- clk  input  1  system clock (50 MHz); all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  8  byte to send.
- tx_dc  input  1  1 = display data, 0 = command; sampled with tx_data.
- tx_valid  input  1  requester has a byte.
- tx_ready  output  1  block can accept a byte this cycle.
- busy  output  1  high whenever the block is not in IDLE.
- lcd_rst  output  1  LCD RST pin, active low.
- lcd_sce  output  1  LCD chip enable, active low.
- lcd_dc  output  1  LCD D/C pin.
- lcd_sclk  output  1  LCD serial clock; the LCD samples on the rising edge.
- lcd_sdin  output  1  LCD serial data.

Behaviour:
- Reset (rst_n = 0, asynchronous), all outputs registered:
  - state = INIT, lcd_rst = 0, lcd_sce = 1, lcd_sclk = 0, lcd_sdin = 0, lcd_dc = 0, tx_ready = 0, busy = 1.
  - All counters are cleared.
- States: INIT, IDLE, SHIFT, HOLD.
- INIT:
  - lcd_rst is held 0 for exactly RST_CYCLES clocks after the first rising edge with rst_n = 1, then goes to 1.
  - Same edge: state goes to IDLE, tx_ready = 1, busy = 0.
- IDLE:
  - lcd_sce = 1, lcd_sclk = 0, tx_ready = 1.
  - Accept occurs on a rising edge where tx_valid & tx_ready.
  - On accept: tx_data is latched into the shift register, tx_dc into lcd_dc; lcd_sce = 0, lcd_sdin = tx_data[7], tx_ready = 0, busy = 1; state goes to SHIFT with bit index 7.
  - tx_data and tx_dc are ignored at all other times.
- SHIFT, for each bit from 7 down to 0:
  - lcd_sclk is low for HALF clocks, then high for HALF clocks.
  - lcd_sdin changes only at the start of a low phase, never while lcd_sclk = 1. This gives HALF clocks of setup and hold around every rising edge.
  - After the high phase of bit 0: lcd_sclk = 0, state goes to HOLD.
- HOLD:
  - lcd_sce stays 0 and lcd_sclk stays 0 for HALF clocks.
  - Then lcd_sce = 1, tx_ready = 1, busy = 0, state goes to IDLE.
- Latency:
  - tx_ready is low for exactly 17·HALF clocks after the accept edge (272 at the default).
  - Exactly 8 rising edges of lcd_sclk occur per byte.
- Frame rules:
  - lcd_dc is constant from the accept edge until lcd_sce rises.
  - lcd_sce is high for at least one clock between consecutive bytes, including back-to-back transfers with tx_valid held high.
- tx_valid while busy has no effect; the requester must hold tx_valid and tx_data until it sees tx_ready.
- rst_n asserted mid-byte aborts the transfer immediately:
  - Outputs return to their reset values and INIT is re-run.
  - No partial byte is resumed.
- Counters are sized with $clog2 of max(HALF, RST_CYCLES)+1; no wrap-around is permitted within any phase.

Test Plan:
- Release reset -> lcd_rst = 0 for exactly 1024 clocks, then 1; tx_ready first high on that same edge; lcd_sce = 1 throughout.
- Send 0xA5 with tx_dc = 1 -> lcd_sce low for 17·16 = 272 clocks; on the 8 lcd_sclk rising edges lcd_sdin reads 1,0,1,0,0,1,0,1; lcd_dc = 1 throughout; period 32 clocks.
- Send 0x21 then 0x0C with tx_dc = 0 and tx_valid held high -> two frames, lcd_sce high ≥ 1 clock between them, decoded bytes 0x21 and 0x0C, lcd_dc = 0.
- Change tx_data to 0xFF and tx_dc mid-transfer of 0x3C -> serialized byte is still 0x3C, lcd_dc unchanged, no extra accept.
- Assert rst_n = 0 after the 3rd lcd_sclk edge -> outputs return to reset values asynchronously; after release, INIT repeats and the next byte serializes correctly.
- HALF = 1 build, send 0x80 -> lcd_sclk period 2 clocks, tx_ready low 17 clocks, decoded byte 0x80.

Source files
------------

// File: rtl/nokia5110_spi_tx.sv
// -----------------------------------------------------------------------------
// nokia5110_spi_tx
//
// Byte-wide serial transmitter for the Nokia 5110 (PCD8544) LCD.  The
// sequencer hands over one byte plus a data/command flag through a
// valid/ready handshake.  The block then shifts the byte out MSB-first on a
// serial clock derived from the system clock, framed by an active-low chip
// enable.  After reset it first drives the LCD hardware-reset pulse.
//
// Serial clock period is 2*HALF system clocks.  Every bit spends HALF clocks
// with lcd_sclk low and then HALF clocks with lcd_sclk high.  lcd_sdin only
// moves at the start of a low phase, so the LCD always sees HALF clocks of
// setup and hold around its sampling edge.
//
// Frame timeline, counted from the accept edge:
//   0        : lcd_sce falls, bit 7 driven, tx_ready falls
//   16*HALF  : last high phase ends, lcd_sclk returns low (HOLD)
//   17*HALF  : lcd_sce rises, tx_ready rises
//
// Parameters:
//   HALF        system clocks per serial-clock half period (>= 1)
//   RST_CYCLES  system clocks lcd_rst is held low after reset release (>= 1)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   tx_data   byte to send, sampled only on the accept edge
//   tx_dc     1 = display data, 0 = command, sampled with tx_data
//   tx_valid  requester has a byte
//   tx_ready  block accepts a byte this cycle
//   busy      block is anywhere but IDLE
//   lcd_rst   LCD reset pin, active low
//   lcd_sce   LCD chip enable, active low
//   lcd_dc    LCD data/command pin
//   lcd_sclk  LCD serial clock (LCD samples on its rising edge)
//   lcd_sdin  LCD serial data
// -----------------------------------------------------------------------------
module nokia5110_spi_tx #(
    parameter int HALF       = 16,
    parameter int RST_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_dc,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       lcd_rst,
    output logic       lcd_sce,
    output logic       lcd_dc,
    output logic       lcd_sclk,
    output logic       lcd_sdin
);

    // One counter serves the reset pulse and every clock phase, so it must
    // hold the larger of the two terminal counts without wrapping.
    localparam int MAX_COUNT = (HALF > RST_CYCLES) ? HALF : RST_CYCLES;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_SHIFT,
        S_HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    sreg_q,  sreg_d;

    logic lcd_rst_q,  lcd_rst_d;
    logic lcd_sce_q,  lcd_sce_d;
    logic lcd_dc_q,   lcd_dc_d;
    logic lcd_sclk_q, lcd_sclk_d;
    logic lcd_sdin_q, lcd_sdin_d;
    logic ready_q,    ready_d;
    logic busy_q,     busy_d;

    logic accept;
    logic phase_done;
    logic init_done;

    // ready_q is registered, so a requester that holds tx_valid high is
    // accepted no earlier than one clock after lcd_sce rises.  That clock
    // is the mandatory chip-enable gap between back-to-back bytes.
    assign accept     = (state_q == S_IDLE) && tx_valid && ready_q;
    assign phase_done = (cnt_q == HALF_LAST);
    // The counter advances on the first edge after release, so lcd_rst is
    // released on the edge where RST_CYCLES full clocks have elapsed.
    assign init_done  = (cnt_q == RST_LAST);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: every flop here is assigned with <= so all of them update from
    // the same pre-edge values; blocking assignments would create ordering
    // dependencies between these registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            bit_q      <= '0;
            sreg_q     <= '0;
            lcd_rst_q  <= 1'b0;
            lcd_sce_q  <= 1'b1;
            lcd_dc_q   <= 1'b0;
            lcd_sclk_q <= 1'b0;
            lcd_sdin_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sreg_q     <= sreg_d;
            lcd_rst_q  <= lcd_rst_d;
            lcd_sce_q  <= lcd_sce_d;
            lcd_dc_q   <= lcd_dc_d;
            lcd_sclk_q <= lcd_sclk_d;
            lcd_sdin_q <= lcd_sdin_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_d is given a default before the case so that every path
    // assigns it; a missing assignment in combinational logic infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:  if (init_done) state_d = S_IDLE;
            S_IDLE:  if (accept) state_d = S_SHIFT;
            // Leave SHIFT only at the end of the high phase of bit 0.
            S_SHIFT: if (phase_done && lcd_sclk_q && (bit_q == 3'd0)) state_d = S_HOLD;
            S_HOLD:  if (phase_done) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and registered-output next values
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sreg_d     = sreg_q;
        lcd_rst_d  = lcd_rst_q;
        lcd_sce_d  = lcd_sce_q;
        lcd_dc_d   = lcd_dc_q;
        lcd_sclk_d = lcd_sclk_q;
        lcd_sdin_d = lcd_sdin_q;

        unique case (state_q)
            S_INIT: begin
                if (init_done) begin
                    cnt_d     = '0;
                    lcd_rst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_IDLE: begin
                cnt_d      = '0;
                lcd_sce_d  = 1'b1;
                lcd_sclk_d = 1'b0;
                if (accept) begin
                    sreg_d     = tx_data;
                    lcd_dc_d   = tx_dc;
                    lcd_sce_d  = 1'b0;
                    lcd_sdin_d = tx_data[7];
                    bit_d      = 3'd7;
                end
            end

            S_SHIFT: begin
                if (phase_done) begin
                    cnt_d = '0;
                    if (!lcd_sclk_q) begin
                        // Low phase over: raise the clock, data stays put.
                        lcd_sclk_d = 1'b1;
                    end else begin
                        // High phase over: new low phase, and the only
                        // point where the next bit may be presented.
                        lcd_sclk_d = 1'b0;
                        if (bit_q != 3'd0) begin
                            bit_d      = bit_q - 3'd1;
                            sreg_d     = {sreg_q[6:0], 1'b0};
                            lcd_sdin_d = sreg_q[6];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_HOLD: begin
                lcd_sclk_d = 1'b0;
                if (phase_done) begin
                    cnt_d     = '0;
                    lcd_sce_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Handshake flags follow the state being entered, so they are valid on
    // the same edge as the transition.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign lcd_rst  = lcd_rst_q;
    assign lcd_sce  = lcd_sce_q;
    assign lcd_dc   = lcd_dc_q;
    assign lcd_sclk = lcd_sclk_q;
    assign lcd_sdin = lcd_sdin_q;

    // Serial data must never move while the serial clock is high.
    a_sdin_stable_high : assert property (
        @(posedge clk) disable iff (!rst_n) lcd_sclk_q |-> $stable(lcd_sdin_q)
    );

endmodule

// File: tb/tb_nokia5110_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_nokia5110_spi_tx
//
// Directed bench for nokia5110_spi_tx.  A default instance (HALF=16,
// RST_CYCLES=1024) carries most of the scenarios; a second instance built
// with HALF=1 covers the fastest serial clock.  A monitor samples the LCD
// pins on the falling system-clock edge and turns each chip-enable frame
// into a record (decoded byte, edge count, timing) that the directed
// sequence compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_nokia5110_spi_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_dc = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, lcd_rst, lcd_sce, lcd_dc, lcd_sclk, lcd_sdin;

    logic [7:0] h1_data = 8'h00;
    logic       h1_dc = 1'b0;
    logic       h1_valid = 1'b0;
    logic       h1_ready, h1_busy, h1_rst, h1_sce, h1_dc_o, h1_sclk, h1_sdin;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nokia5110_spi_tx #(.HALF(16), .RST_CYCLES(1024)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_dc    (tx_dc),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .lcd_rst  (lcd_rst),
        .lcd_sce  (lcd_sce),
        .lcd_dc   (lcd_dc),
        .lcd_sclk (lcd_sclk),
        .lcd_sdin (lcd_sdin)
    );

    nokia5110_spi_tx #(.HALF(1), .RST_CYCLES(4)) dut_h1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (h1_data),
        .tx_dc    (h1_dc),
        .tx_valid (h1_valid),
        .tx_ready (h1_ready),
        .busy     (h1_busy),
        .lcd_rst  (h1_rst),
        .lcd_sce  (h1_sce),
        .lcd_dc   (h1_dc_o),
        .lcd_sclk (h1_sclk),
        .lcd_sdin (h1_sdin)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Frame monitor (default instance)
    // ---------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        int         edges;
        int         sce_low;
        logic       dc;
        bit         dc_bad;
        bit         sdin_bad;
        int         per_min;
        int         per_max;
        int         gap;
        int         rdy_low;
    } frame_t;

    frame_t frames[$];
    int     rise_total = 0;

    initial begin : monitor
        frame_t cur;
        bit     in_frame;
        logic   p_sce, p_sclk, p_sdin;
        int     since_rise, gap_cnt, rdy_cnt;
        in_frame = 0; p_sce = 1'b1; p_sclk = 1'b0; p_sdin = 1'b0;
        since_rise = -1; gap_cnt = 0; rdy_cnt = 0;
        cur = '{8'h00, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                // Aborted frames are discarded, never reported.
                in_frame = 0; p_sce = 1'b1; p_sclk = 1'b0; p_sdin = 1'b0;
                gap_cnt = 0; rdy_cnt = 0;
            end else begin
                if (p_sce && !lcd_sce) begin
                    in_frame = 1;
                    cur = '{8'h00, 0, 0, lcd_dc, 0, 0, 1000000, 0, gap_cnt, 0};
                    since_rise = -1;
                end
                if (lcd_sclk && !p_sclk) rise_total++;
                if (in_frame && !lcd_sce) begin
                    cur.sce_low++;
                    if (lcd_dc !== cur.dc) cur.dc_bad = 1;
                    if (lcd_sclk && (lcd_sdin !== p_sdin)) cur.sdin_bad = 1;
                    if (since_rise >= 0) since_rise++;
                    if (lcd_sclk && !p_sclk) begin
                        cur.edges++;
                        cur.data = {cur.data[6:0], lcd_sdin};
                        if (since_rise > 0) begin
                            if (since_rise < cur.per_min) cur.per_min = since_rise;
                            if (since_rise > cur.per_max) cur.per_max = since_rise;
                        end
                        since_rise = 0;
                    end
                end
                if (!tx_ready) rdy_cnt++;
                if (in_frame && lcd_sce && !p_sce) begin
                    cur.rdy_low = rdy_cnt;
                    frames.push_back(cur);
                    in_frame = 0;
                end
                if (tx_ready) rdy_cnt = 0;
                if (lcd_sce) gap_cnt++;
                else gap_cnt = 0;
                p_sce = lcd_sce; p_sclk = lcd_sclk; p_sdin = lcd_sdin;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Sequencing helpers
    // ---------------------------------------------------------------------
    // Counts clocks with lcd_rst low after rst_n release and checks that
    // tx_ready first rises together with lcd_rst.
    task automatic check_init(input string tag);
        int  low_cnt;
        bit  sce_bad, early;
        low_cnt = 0; sce_bad = 0; early = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (lcd_sce !== 1'b1) sce_bad = 1;
            if (lcd_rst === 1'b1) break;
            if (tx_ready !== 1'b0) early = 1;
            low_cnt++;
        end
        check({tag, "_rst_low_cycles"}, low_cnt, 1024);
        check({tag, "_rst_high"}, lcd_rst, 1'b1);
        check({tag, "_ready_with_rst"}, tx_ready, 1'b1);
        check({tag, "_busy_idle"}, busy, 1'b0);
        check({tag, "_ready_early"}, early, 0);
        check({tag, "_sce_high"}, sce_bad, 0);
    endtask

    // Presents a byte, waits (bounded) for the accept edge, then either
    // drops tx_valid or leaves it asserted.
    task automatic send(input logic [7:0] d, input logic dc, input bit hold);
        @(negedge clk);
        tx_data = d; tx_dc = dc; tx_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        check("accept_ready_seen", tx_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag, output frame_t f);
        bit got;
        got = 0;
        f = '{8'h00, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 1000; i++) begin
            #1;
            if (frames.size() > 0) begin
                f = frames.pop_front();
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_frame_seen"}, got, 1);
    endtask

    task automatic check_frame(input string tag, input frame_t f,
                               input logic [7:0] exp_data, input logic exp_dc);
        check({tag, "_byte"}, f.data, exp_data);
        check({tag, "_sclk_rises"}, f.edges, 8);
        check({tag, "_sce_low"}, f.sce_low, 272);
        check({tag, "_dc"}, f.dc, exp_dc);
        check({tag, "_dc_const"}, f.dc_bad, 0);
        check({tag, "_sdin_in_high"}, f.sdin_bad, 0);
        check({tag, "_period_min"}, f.per_min, 32);
        check({tag, "_period_max"}, f.per_max, 32);
        check({tag, "_ready_low"}, f.rdy_low, 272);
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin : stim
        frame_t f, f2;
        int     base;
        int     rdy_low, rises, since, per_min, per_max;
        logic [7:0] h1_byte;
        logic   psclk;

        // Reset values while rst_n is held low.
        #12;
        check("rst_lcd_rst", lcd_rst, 1'b0);
        check("rst_sce", lcd_sce, 1'b1);
        check("rst_sclk", lcd_sclk, 1'b0);
        check("rst_sdin", lcd_sdin, 1'b0);
        check("rst_dc", lcd_dc, 1'b0);
        check("rst_ready", tx_ready, 1'b0);
        check("rst_busy", busy, 1'b1);

        check_init("init1");

        // 0xA5 as display data: bits 1,0,1,0,0,1,0,1.
        send(8'hA5, 1'b1, 0);
        wait_frame("a5", f);
        check_frame("a5", f, 8'hA5, 1'b1);

        // Two commands back to back with tx_valid held high.
        send(8'h21, 1'b0, 1);
        tx_data = 8'h0C;
        wait_frame("b2b1", f);
        check_frame("b2b1", f, 8'h21, 1'b0);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_frame("b2b2", f2);
        check_frame("b2b2", f2, 8'h0C, 1'b0);
        check("b2b_gap_ge1", (f2.gap >= 1), 1'b1);

        // Inputs change mid-transfer with tx_valid still high: ignored.
        send(8'h3C, 1'b0, 1);
        tx_data = 8'hFF; tx_dc = 1'b1;
        repeat (100) @(negedge clk);
        tx_valid = 1'b0;
        wait_frame("chg", f);
        check_frame("chg", f, 8'h3C, 1'b0);
        repeat (50) @(negedge clk);
        check("chg_no_extra_frame", frames.size(), 0);
        check("chg_sce_idle", lcd_sce, 1'b1);
        check("chg_ready_idle", tx_ready, 1'b1);

        // Abort mid-byte after the third serial clock edge.
        base = rise_total;
        send(8'hE7, 1'b1, 0);
        for (int i = 0; i < 500; i++) begin
            if (rise_total >= base + 3) break;
            @(negedge clk);
        end
        check("abort_three_rises", rise_total - base, 3);
        check("abort_sdin_before", lcd_sdin, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_lcd_rst", lcd_rst, 1'b0);
        check("abort_sce", lcd_sce, 1'b1);
        check("abort_sclk", lcd_sclk, 1'b0);
        check("abort_sdin", lcd_sdin, 1'b0);
        check("abort_dc", lcd_dc, 1'b0);
        check("abort_ready", tx_ready, 1'b0);
        check("abort_busy", busy, 1'b1);
        repeat (3) @(negedge clk);
        check_init("init2");
        check("abort_no_partial_frame", frames.size(), 0);
        send(8'h96, 1'b1, 0);
        wait_frame("post", f);
        check_frame("post", f, 8'h96, 1'b1);

        // HALF = 1 instance: 0x80, 2-clock serial period, 17 clocks busy.
        @(negedge clk);
        check("h1_ready_idle", h1_ready, 1'b1);
        h1_data = 8'h80; h1_dc = 1'b1; h1_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        h1_valid = 1'b0;
        rdy_low = 0; rises = 0; since = -1; per_min = 1000; per_max = 0;
        h1_byte = 8'h00; psclk = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (h1_ready) break;
            rdy_low++;
            if (since >= 0) since++;
            if (h1_sclk && !psclk) begin
                rises++;
                h1_byte = {h1_byte[6:0], h1_sdin};
                if (since > 0) begin
                    if (since < per_min) per_min = since;
                    if (since > per_max) per_max = since;
                end
                since = 0;
            end
            psclk = h1_sclk;
            @(negedge clk);
        end
        check("h1_ready_low", rdy_low, 17);
        check("h1_byte", h1_byte, 8'h80);
        check("h1_rises", rises, 8);
        check("h1_period_min", per_min, 2);
        check("h1_period_max", per_max, 2);
        check("h1_sce_end", h1_sce, 1'b1);
        check("h1_dc", h1_dc_o, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the bench always ends on its own.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
